// File: rtl/uart_tx_mmio_pkg.sv
// ============================================================================
// Module      : uart_tx_mmio_pkg
// Description : Shared constants and types for the memory-mapped UART TX.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_tx_mmio_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CTRL   = 2'd2;
    localparam logic [1:0] UART_BAUD   = 2'd3;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    localparam int CTRL_TX_EN = 0;
    localparam int CTRL_IE    = 1;

    localparam logic [1:0] CTRL_RESET = 2'b01;
    localparam logic       RST_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_mmio_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous circular FIFO feeding the UART serialiser.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_fifo
    import uart_tx_mmio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO still lands when a pop frees a slot the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// ============================================================================
// Module      : uart_tx_mmio
// Description : Bus-mapped 8N1 UART transmitter with TX FIFO and idle IRQ.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        txd,
    output logic        int_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          w_hit;
    logic          w_wr;
    logic [1:0]    w_reg;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_fifo_dout;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [31:0]   w_status;
    logic          w_can_start;
    logic          w_bit_end;
    logic          w_unused;

    logic          r_tx_en;
    logic          r_ie;
    logic          r_ovf;
    logic [15:0]   r_baud;

    tx_state_t     r_state;
    logic [15:0]   r_div;
    logic [15:0]   r_baud_cnt;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_idx;

    assign w_hit  = ce && (addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr   = w_hit && we;
    assign w_reg  = addr[3:2];
    assign w_push = w_wr && (w_reg == UART_TXDATA) && sel[0];

    assign w_unused = ^{addr[1:0], sel[3:2], data_i[31:16]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_i[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_tx_en <= CTRL_RESET[CTRL_TX_EN];
            r_ie    <= CTRL_RESET[CTRL_IE];
            r_baud  <= DEFAULT_DIV;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr && (w_reg == UART_CTRL) && sel[0]) begin
                r_tx_en <= data_i[CTRL_TX_EN];
                r_ie    <= data_i[CTRL_IE];
            end
            if (w_wr && (w_reg == UART_BAUD)) begin
                if (sel[0]) r_baud[7:0]  <= data_i[7:0];
                if (sel[1]) r_baud[15:8] <= data_i[15:8];
            end
            // A dropped push wins over a simultaneous clear so no loss goes unreported.
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_reg == UART_STATUS) && sel[0] && data_i[STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status                       = '0;
        w_status[STAT_FULL]            = w_full;
        w_status[STAT_EMPTY]           = w_empty;
        w_status[STAT_BUSY]            = (r_state != ST_IDLE);
        w_status[STAT_OVF]             = r_ovf;
        w_status[STAT_CNT_LSB +: 8]    = 8'(w_count);
    end

    always_comb begin
        data_o = '0;
        if (w_hit && !we) begin
            case (w_reg)
                UART_TXDATA: data_o = '0;
                UART_STATUS: data_o = w_status;
                UART_CTRL:   data_o = {30'd0, r_ie, r_tx_en};
                default:     data_o = {16'd0, r_baud};
            endcase
        end
    end

    assign w_can_start = r_tx_en && !w_empty;
    assign w_bit_end   = (r_baud_cnt == 16'd0);
    assign w_pop       = w_can_start &&
                         ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_state    <= ST_IDLE;
            r_div      <= DEFAULT_DIV;
            r_baud_cnt <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            txd        <= 1'b1;
            int_o      <= 1'b0;
        end else begin
            int_o <= r_ie && w_empty && (r_state == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (w_pop) begin
                        r_shift    <= w_fifo_dout;
                        r_div      <= r_baud;
                        r_baud_cnt <= r_baud;
                        r_state    <= ST_START;
                        txd        <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= r_div;
                        r_bit_idx  <= 3'd0;
                        r_state    <= ST_DATA;
                        txd        <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= r_div;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                            txd     <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            txd       <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        // Chain straight into the next frame when data is waiting.
                        if (w_pop) begin
                            r_shift    <= w_fifo_dout;
                            r_div      <= r_baud;
                            r_baud_cnt <= r_baud;
                            r_state    <= ST_START;
                            txd        <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    txd     <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the SOPC data bus, alongside data_ram and downstream of the OpenMIPS ram_* outputs. CPU stores push bytes into a TX FIFO; a baud-paced FSM serialises them 8N1 on txd. A registered level interrupt, tx-idle, drives the int_i bit 1 input of OpenMIPS.

Parameters:
BASE_ADDR, 32'h1000_0000, word-aligned base; block decodes addr[31:4] == BASE_ADDR[31:4]
FIFO_DEPTH, 16, TX FIFO entries (power of 2, >=2)
DEFAULT_DIV, 16'd433, reset value of BAUDDIV; bit period = BAUDDIV+1 clocks

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ce  in  1  data bus chip enable (ram_ce_o)
we  in  1  write enable (ram_we_o)
addr  in  32  byte address (ram_addr_o)
sel  in  4  byte lanes (ram_sel_o)
data_i  in  32  write data (ram_data_o)
data_o  out  32  read data, to the CPU load mux
txd  out  1  serial output, idle high
int_o  out  1  tx-idle interrupt, level, registered

Behaviour:
- Register map, addr[3:2]: 0 TXDATA (write-only, reads 0); 1 STATUS; 2 CTRL; 3 BAUDDIV.
- hit = ce & addr decode. Writes take effect on the clk edge when hit & we. Reads are combinational: data_o = selected register when hit & !we, else 32'h0.
- TXDATA write with sel[0]=1 pushes data_i[7:0]. Writes with sel[0]=0 are ignored.
- STATUS: [0] full, [1] empty, [2] busy (FSM != IDLE), [3] overflow (sticky), [15:8] FIFO count. Writing 1 to bit 3 clears overflow. Other bits are read-only.
- CTRL: [0] tx_en, [1] ie. Write honours sel[0]. Reset value 2'b01.
- BAUDDIV: [15:0]. Write honours sel[1:0] per byte. Reset value DEFAULT_DIV. The value is latched into the working divisor at frame start, so a mid-frame write affects the next frame only.
- FIFO: circular, separate rd/wr pointers plus count.
  - Push while full: byte dropped, overflow set.
  - Push and pop in the same cycle: both take effect, including when full.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: txd=1. If tx_en & !empty, pop into shift register, latch divisor, load baud counter, go START, txd<=0. A byte written at edge k into an empty FIFO drives txd low after edge k+1.
  - START, DATA, STOP: each lasts BAUDDIV+1 clocks. The baud counter counts down and the bit ends at 0.
  - DATA: 8 bits, LSB first, bit index 0..7.
  - STOP: txd=1 for one bit. At its end, pop the next byte directly if tx_en & !empty (back-to-back frames, no idle gap). Otherwise go IDLE.
  - Clearing tx_en mid-frame completes the current frame, then holds in IDLE.
- int_o <= ie & empty & (state==IDLE), registered one cycle.
- Reset (async, any time including mid-frame):
  - txd=1, int_o=0, state IDLE.
  - FIFO emptied, overflow=0, CTRL=2'b01, BAUDDIV=DEFAULT_DIV.
  - data_o is combinational: 0 unless hit & !we.
- Arithmetic: count width = clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH. The baud counter is 16 bit.

Decomposition:
- Shared package/defines: register offsets (UART_TXDATA=2'd0, UART_STATUS, UART_CTRL, UART_BAUD), STATUS/CTRL bit positions, FSM state encodings (2-bit), the reset-level constant for active-low reset.
- One sub-module: uart_tx_fifo (sync FIFO: push, pop, din, dout, full, empty, count). FSM, baud counter and register file stay in uart_tx_mmio.

Test Plan:
- Reset defaults: rst low mid-frame -> txd=1, int_o=0, STATUS read = 32'h0000_0002, CTRL=1, BAUDDIV=433.
- Single byte: BAUDDIV=3, write 8'hA5 to TXDATA -> txd low at edge k+1, then bits 1,0,1,0,0,1,0,1 each 4 clocks, stop high 4 clocks; busy then clears.
- Back-to-back: BAUDDIV=1, push 8'h55, 8'h0F, 8'h81 -> three contiguous 20-clock frames, no idle gap, STATUS empty=1 afterwards.
- Overflow: tx_en=0, push 17 bytes -> count=16, full=1, overflow=1. Write STATUS 32'h8 -> overflow=0. Enable -> the first 16 bytes are sent in order.
- Interrupt: CTRL=3, send one byte -> int_o=0 during the frame and 1 one cycle after IDLE with empty. CTRL=1 -> int_o=0.
- Bus corner cases:
  - TXDATA write with sel=4'b1000 -> no push.
  - Read with ce=0 -> data_o=0.
  - Address BASE_ADDR+16'h20 -> no hit.
  - BAUDDIV write mid-frame -> current frame keeps the old period.
